// File: rtl/board_color_store.sv
// Colour-board store: erase/paint falling piece, shift rows down on clear, registered read port.
// Optional CLEAR_COUNT_EN adds a saturating lines_cleared counter output.
module board_color_store #(
    parameter int          BOARD_W  = 10,
    parameter int          BOARD_H  = 20,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Update,
    input  logic [6:0]  blockXPos [4],
    input  logic [6:0]  blockYPos [4],
    input  logic [6:0]  blockXPrev [4],
    input  logic [6:0]  blockYPrev [4],
    input  logic [15:0] blockColor,
    input  logic        Clear_row,
    input  logic [3:0]  Num_rows_to_clear,
    input  logic [6:0]  Row_to_clear,
    input  logic [6:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic [15:0] rd_color,
`ifdef CLEAR_COUNT_EN
    output logic [15:0] lines_cleared,
`endif
    output logic        busy
);

    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);

    typedef enum logic [1:0] {IDLE, ERASE, PAINT, SHIFT} state_t;

    typedef struct packed {
        logic [3:0][6:0] xc;
        logic [3:0][6:0] yc;
        logic [3:0][6:0] xp;
        logic [3:0][6:0] yp;
        logic [15:0]     col;
    } upd_t;

    typedef struct packed {
        logic [2:0]    n;
        logic [YW-1:0] row;
    } clr_t;

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic [2:0]    sh_n_q, sh_n_d;
    upd_t          ua_q, ua_d;
    upd_t          up_q, up_d;
    logic          upend_q, upend_d;
    clr_t          cp_q, cp_d;
    logic          cpend_q, cpend_d;
    logic [15:0]   rd_q;
    logic [15:0]   cell_q [BOARD_H][BOARD_W];

    upd_t        upd_new, upd_src;
    clr_t        clr_new, clr_src;
    logic        clr_ok;
    logic [2:0]  n4;
    logic [6:0]  rowp1;
    logic [YW-1:0] src_y;
    logic        we, we_ok;
    logic [6:0]  wx, wy;
    logic [15:0] wdat;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            upd_new.xc[i] = blockXPos[i];
            upd_new.yc[i] = blockYPos[i];
            upd_new.xp[i] = blockXPrev[i];
            upd_new.yp[i] = blockYPrev[i];
        end
        upd_new.col = blockColor;
        n4 = (Num_rows_to_clear > 4'd4) ? 3'd4 : Num_rows_to_clear[2:0];
        rowp1 = Row_to_clear + 7'd1;
        clr_new.n = ({4'b0, n4} > rowp1) ? rowp1[2:0] : n4;
        clr_new.row = Row_to_clear[YW-1:0];
        clr_ok = Clear_row && (Num_rows_to_clear != 4'd0)
              && (Row_to_clear < 7'(BOARD_H));
        upd_src = Update ? upd_new : up_q;
        clr_src = clr_ok ? clr_new : cp_q;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sh_n_d  = sh_n_q;
        ua_d    = ua_q;
        up_d    = up_q;
        upend_d = upend_q;
        cp_d    = cp_q;
        cpend_d = cpend_q;
        we      = 1'b0;
        wx      = '0;
        wy      = '0;
        wdat    = BG_COLOR;
        src_y   = sy_q - YW'(sh_n_q);

        // Strobes arriving while busy are parked; the latest one wins.
        if (state_q != IDLE) begin
            if (clr_ok) begin
                cpend_d = 1'b1;
                cp_d    = clr_new;
            end
            if (Update) begin
                upend_d = 1'b1;
                up_d    = upd_new;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (clr_ok || cpend_q) begin
                    state_d = SHIFT;
                    sh_n_d  = clr_src.n;
                    sy_d    = clr_src.row;
                    sx_d    = '0;
                    cpend_d = 1'b0;
                    if (Update) begin
                        upend_d = 1'b1;
                        up_d    = upd_new;
                    end
                end else if (Update || upend_q) begin
                    ua_d    = upd_src;
                    upend_d = 1'b0;
                    k_d     = 2'd0;
                    state_d = ((upd_src.xp == '0) && (upd_src.yp == '0))
                            ? PAINT : ERASE;
                end
            end
            ERASE: begin
                we   = 1'b1;
                wx   = ua_q.xp[k_q];
                wy   = ua_q.yp[k_q];
                wdat = BG_COLOR;
                k_d  = k_q + 2'd1;
                if (k_q == 2'd3) state_d = PAINT;
            end
            PAINT: begin
                we   = 1'b1;
                wx   = ua_q.xc[k_q];
                wy   = ua_q.yc[k_q];
                wdat = ua_q.col;
                k_d  = k_q + 2'd1;
                if (k_q == 2'd3) state_d = IDLE;
            end
            SHIFT: begin
                // Bottom-up walk: source rows above are still unmodified.
                we   = 1'b1;
                wx   = 7'(sx_q);
                wy   = 7'(sy_q);
                wdat = (sy_q >= YW'(sh_n_q)) ? cell_q[src_y][sx_q] : BG_COLOR;
                if (sx_q == XW'(BOARD_W - 1)) begin
                    sx_d = '0;
                    if (sy_q == '0) state_d = IDLE;
                    else            sy_d = sy_q - YW'(1);
                end else begin
                    sx_d = sx_q + XW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        we_ok = we && (wx < 7'(BOARD_W)) && (wy < 7'(BOARD_H));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            sh_n_q  <= '0;
            ua_q    <= '0;
            up_q    <= '0;
            upend_q <= 1'b0;
            cp_q    <= '0;
            cpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sh_n_q  <= sh_n_d;
            ua_q    <= ua_d;
            up_q    <= up_d;
            upend_q <= upend_d;
            cp_q    <= cp_d;
            cpend_q <= cpend_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int y = 0; y < BOARD_H; y++)
                for (int x = 0; x < BOARD_W; x++)
                    cell_q[y][x] <= BG_COLOR;
        end else if (we_ok) begin
            cell_q[wy[YW-1:0]][wx[XW-1:0]] <= wdat;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            rd_q <= BG_COLOR;
        else if ((rd_x < 7'(BOARD_W)) && (rd_y < 7'(BOARD_H)))
            rd_q <= cell_q[rd_y[YW-1:0]][rd_x[XW-1:0]];
        else
            rd_q <= BG_COLOR;
    end

`ifdef CLEAR_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 17'(clr_src.n);
        cnt_d   = cnt_q;
        if ((state_q == IDLE) && (clr_ok || cpend_q))
            cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign lines_cleared = cnt_q;
`endif

    assign rd_color = rd_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_board_color_store.sv
// Directed self-checking bench for board_color_store.
// Define CLEAR_COUNT_EN to also exercise the lines_cleared counter.
module tb_board_color_store;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upd = 1'b0;
    logic [6:0]  bxp [4];
    logic [6:0]  byp [4];
    logic [6:0]  bxv [4];
    logic [6:0]  byv [4];
    logic [15:0] color = '0;
    logic        clr = 1'b0;
    logic [3:0]  nclr = '0;
    logic [6:0]  rclr = '0;
    logic [6:0]  rx = '0;
    logic [6:0]  ry = '0;
    logic [15:0] rd_color;
    logic        busy;
`ifdef CLEAR_COUNT_EN
    logic [15:0] lines_cleared;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    board_color_store dut (
        .Clk(clk), .Reset(rst), .Update(upd),
        .blockXPos(bxp), .blockYPos(byp),
        .blockXPrev(bxv), .blockYPrev(byv),
        .blockColor(color), .Clear_row(clr),
        .Num_rows_to_clear(nclr), .Row_to_clear(rclr),
        .rd_x(rx), .rd_y(ry), .rd_color(rd_color),
`ifdef CLEAR_COUNT_EN
        .lines_cleared(lines_cleared),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic rd(input int x, input int y, output logic [15:0] c);
        rx = 7'(x);
        ry = 7'(y);
        @(negedge clk);
        c = rd_color;
    endtask

    task automatic set_cells(input logic [27:0] xs, input logic [27:0] ys,
                             input logic [27:0] xv, input logic [27:0] yv,
                             input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            bxp[i] = xs[i*7 +: 7];
            byp[i] = ys[i*7 +: 7];
            bxv[i] = xv[i*7 +: 7];
            byv[i] = yv[i*7 +: 7];
        end
        color = c;
    endtask

    task automatic put(input int x, input int y, input logic [15:0] c);
        int n;
        logic [6:0] x7, y7;
        x7 = 7'(x);
        y7 = 7'(y);
        set_cells({4{x7}}, {4{y7}}, '0, '0, c);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wait_idle(n);
    endtask

    task automatic strobe_clear(input logic [3:0] n, input logic [6:0] r);
        nclr = n;
        rclr = r;
        clr  = 1'b1;
        @(negedge clk);
        clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] c;
        do_reset();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                rd(x, y, c);
                n_cmp++;
                if (c !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL reset_cell(%0d,%0d) got=%h exp=0000", x, y, c);
                end
            end
    endtask

    task automatic test_update();
        int n;
        logic [15:0] c;
        set_cells({7'd5, 7'd5, 7'd4, 7'd4}, {7'd2, 7'd1, 7'd1, 7'd0},
                  '0, '0, 16'h0f00);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        set_cells('0, '0, '0, '0, 16'h1234);
        wait_idle(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL upd_busy_cycles got=%0d exp=4", n);
        end
        rd(4, 0, c); n_cmp++;
        if (c !== 16'h0f00) begin n_bad++; $display("FAIL upd_4_0 got=%h exp=0f00", c); end
        rd(4, 1, c); n_cmp++;
        if (c !== 16'h0f00) begin n_bad++; $display("FAIL upd_4_1 got=%h exp=0f00", c); end
        rd(5, 1, c); n_cmp++;
        if (c !== 16'h0f00) begin n_bad++; $display("FAIL upd_5_1 got=%h exp=0f00", c); end
        rd(5, 2, c); n_cmp++;
        if (c !== 16'h0f00) begin n_bad++; $display("FAIL upd_5_2 got=%h exp=0f00", c); end
        rd(0, 0, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL upd_0_0 got=%h exp=0000", c); end
        set_cells({7'd5, 7'd5, 7'd4, 7'd4}, {7'd3, 7'd2, 7'd2, 7'd1},
                  {7'd5, 7'd5, 7'd4, 7'd4}, {7'd2, 7'd1, 7'd1, 7'd0}, 16'h0f00);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wait_idle(n);
        n_cmp++;
        if (n !== 8) begin n_bad++; $display("FAIL move_busy_cycles got=%0d exp=8", n); end
        rd(4, 0, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL move_4_0 got=%h exp=0000", c); end
        rd(5, 1, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL move_5_1 got=%h exp=0000", c); end
        rd(4, 1, c); n_cmp++;
        if (c !== 16'h0f00) begin n_bad++; $display("FAIL move_4_1 got=%h exp=0f00", c); end
        rd(5, 3, c); n_cmp++;
        if (c !== 16'h0f00) begin n_bad++; $display("FAIL move_5_3 got=%h exp=0f00", c); end
        rd(12, 3, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL oob_read got=%h exp=0000", c); end
    endtask

    task automatic test_clear();
        int n;
        logic [15:0] c;
        do_reset();
        for (int x = 0; x < 10; x++) put(x, 19, 16'h05f0);
        put(3, 18, 16'h00a8);
        strobe_clear(4'd1, 7'd19);
        wait_idle(n);
        n_cmp++;
        if (n !== 200) begin n_bad++; $display("FAIL clr_busy_cycles got=%0d exp=200", n); end
        rd(3, 19, c); n_cmp++;
        if (c !== 16'h00a8) begin n_bad++; $display("FAIL clr_3_19 got=%h exp=00a8", c); end
        rd(0, 19, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL clr_0_19 got=%h exp=0000", c); end
        rd(9, 19, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL clr_9_19 got=%h exp=0000", c); end
        rd(3, 18, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL clr_3_18 got=%h exp=0000", c); end
        for (int x = 0; x < 10; x++) begin
            rd(x, 0, c); n_cmp++;
            if (c !== 16'h0000) begin n_bad++; $display("FAIL clr_row0_%0d got=%h exp=0000", x, c); end
        end
    endtask

    task automatic test_clamp();
        int n;
        logic [15:0] c;
        do_reset();
        put(0, 15, 16'h1111);
        put(9, 15, 16'h2222);
        put(2, 0, 16'h3333);
        strobe_clear(4'd9, 7'd19);
        wait_idle(n);
        n_cmp++;
        if (n !== 200) begin n_bad++; $display("FAIL n9_busy_cycles got=%0d exp=200", n); end
        rd(0, 19, c); n_cmp++;
        if (c !== 16'h1111) begin n_bad++; $display("FAIL n9_0_19 got=%h exp=1111", c); end
        rd(9, 19, c); n_cmp++;
        if (c !== 16'h2222) begin n_bad++; $display("FAIL n9_9_19 got=%h exp=2222", c); end
        rd(0, 15, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL n9_0_15 got=%h exp=0000", c); end
        rd(2, 4, c); n_cmp++;
        if (c !== 16'h3333) begin n_bad++; $display("FAIL n9_2_4 got=%h exp=3333", c); end
        rd(2, 0, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL n9_2_0 got=%h exp=0000", c); end
        strobe_clear(4'd0, 7'd19);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL n0_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL n0_busy_later got=%b exp=0", busy); end
        strobe_clear(4'd1, 7'd20);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL row20_busy got=%b exp=0", busy); end
        put(1, 1, 16'h4444);
        strobe_clear(4'd4, 7'd1);
        wait_idle(n);
        n_cmp++;
        if (n !== 20) begin n_bad++; $display("FAIL row1_busy_cycles got=%0d exp=20", n); end
        rd(1, 1, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL row1_1_1 got=%h exp=0000", c); end
        rd(2, 5, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL row1_2_5 got=%h exp=0000", c); end
    endtask

    task automatic test_same_cycle();
        int n;
        logic [15:0] c;
        do_reset();
        put(0, 19, 16'haaaa);
        set_cells({4{7'd7}}, {7'd8, 7'd7, 7'd6, 7'd5},
                  {4{7'd0}}, {4{7'd19}}, 16'hbbbb);
        nclr = 4'd1;
        rclr = 7'd19;
        upd  = 1'b1;
        clr  = 1'b1;
        @(negedge clk);
        upd  = 1'b0;
        clr  = 1'b0;
        set_cells({4{7'd2}}, {4{7'd5}}, '0, '0, 16'h1234);
        wait_idle(n);
        n_cmp++;
        if (n !== 200) begin n_bad++; $display("FAIL sc_shift_cycles got=%0d exp=200", n); end
        @(negedge clk);
        wait_idle(n);
        n_cmp++;
        if (n !== 8) begin n_bad++; $display("FAIL sc_upd_cycles got=%0d exp=8", n); end
        rd(0, 19, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL sc_0_19 got=%h exp=0000", c); end
        rd(7, 8, c); n_cmp++;
        if (c !== 16'hbbbb) begin n_bad++; $display("FAIL sc_7_8 got=%h exp=bbbb", c); end
        rd(7, 9, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL sc_7_9 got=%h exp=0000", c); end
        rd(7, 5, c); n_cmp++;
        if (c !== 16'hbbbb) begin n_bad++; $display("FAIL sc_7_5 got=%h exp=bbbb", c); end
        rd(2, 5, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL sc_2_5 got=%h exp=0000", c); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] c;
        do_reset();
        strobe_clear(4'd1, 7'd19);
        set_cells({4{7'd1}}, {4{7'd1}}, '0, '0, 16'hcccc);
        upd = 1'b1;
        @(negedge clk);
        set_cells({4{7'd2}}, {4{7'd2}}, '0, '0, 16'hdddd);
        @(negedge clk);
        upd = 1'b0;
        wait_idle(n);
        n_cmp++;
        if (n + 2 !== 200) begin n_bad++; $display("FAIL b2b_shift_cycles got=%0d exp=200", n + 2); end
        @(negedge clk);
        wait_idle(n);
        n_cmp++;
        if (n !== 4) begin n_bad++; $display("FAIL b2b_upd_cycles got=%0d exp=4", n); end
        rd(2, 2, c); n_cmp++;
        if (c !== 16'hdddd) begin n_bad++; $display("FAIL b2b_2_2 got=%h exp=dddd", c); end
        rd(1, 1, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL b2b_1_1 got=%h exp=0000", c); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] c;
        do_reset();
        put(5, 10, 16'heeee);
        strobe_clear(4'd1, 7'd19);
        set_cells({4{7'd8}}, {4{7'd8}}, '0, '0, 16'hffff);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        repeat (48) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
        rst = 1'b0;
        rd(5, 10, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL mid_5_10 got=%h exp=0000", c); end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_pending got=%b exp=0", busy); end
        rd(8, 8, c); n_cmp++;
        if (c !== 16'h0000) begin n_bad++; $display("FAIL mid_8_8 got=%h exp=0000", c); end
`ifdef CLEAR_COUNT_EN
        n_cmp++;
        if (lines_cleared !== 16'd0) begin
            n_bad++; $display("FAIL cnt_reset got=%0d exp=0", lines_cleared);
        end
        strobe_clear(4'd2, 7'd19);
        wait_idle(n);
        strobe_clear(4'd2, 7'd19);
        wait_idle(n);
        strobe_clear(4'd0, 7'd19);
        n_cmp++;
        if (lines_cleared !== 16'd4) begin
            n_bad++; $display("FAIL cnt_two_clears got=%0d exp=4", lines_cleared);
        end
        do_reset();
        n_cmp++;
        if (lines_cleared !== 16'd0) begin
            n_bad++; $display("FAIL cnt_rereset got=%0d exp=0", lines_cleared);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            bxp[i] = '0; byp[i] = '0; bxv[i] = '0; byv[i] = '0;
        end
        @(negedge clk);
        test_reset();
        test_update();
        test_clear();
        test_clamp();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
